// File: rtl/menu_nav_ctl.sv
// menu_nav_ctl
// Main-menu navigation controller. Turns held button levels into a cursor
// row with auto-repeat, a highlight strobe aligned with the text ROM's
// registered char_code, and a valid/ready mode offer to the game core.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   btn_up/down   cursor movement levels (auto-repeat while held)
//   btn_enter     select the current row
//   btn_esc       abort an offer, or leave running mode
//   char_xy       renderer char address, [7:4] row, [3:0] column
//   mode_ready    game core accepts the offered mode
//   game_done     1-cycle pulse, game finished
//   sel_item      cursor row
//   highlight     current char is on the highlighted row (1-cycle latency)
//   mode_valid    mode offer to the game core
//   mode          selected row, stable while mode_valid
//   menu_active   menu is on screen
//
// state     | meaning
// ----------+------------------------------------------------------
// S_MENU    | cursor moves, enter offers the current row
// S_CONFIRM | offer pending, highlight blinks, esc withdraws
// S_RUN     | game running, menu hidden
module menu_nav_ctl #(
   parameter int          N_ITEMS      = 4,
   parameter logic [31:0] REPEAT_DELAY = 32'd20_000_000,
   parameter logic [31:0] REPEAT_RATE  = 32'd5_000_000,
   parameter logic [31:0] BLINK_DIV    = 32'd10_000_000,
   localparam int         W            = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         btn_up,
   input  logic         btn_down,
   input  logic         btn_enter,
   input  logic         btn_esc,
   input  logic [7:0]   char_xy,
   input  logic         mode_ready,
   input  logic         game_done,
   output logic [W-1:0] sel_item,
   output logic         highlight,
   output logic         mode_valid,
   output logic [W-1:0] mode,
   output logic         menu_active
);

   typedef enum logic [1:0] {S_MENU, S_CONFIRM, S_RUN} state_t;

   localparam logic [W-1:0] LAST  = W'(N_ITEMS - 1);
   localparam logic [4:0]   N_LIM = 5'(N_ITEMS);

   state_t      state;
   logic        up_q, dn_q, ent_q, esc_q;
   logic        up_arm, dn_arm;
   logic [31:0] up_tmr, dn_tmr, blink_tmr;
   logic        blink_en;

   logic        up_p, dn_p, ent_p, esc_p, hl_en;
   logic [4:0]  row;

   function automatic logic [W-1:0] next_row(input logic [W-1:0] s);
      return (s == LAST) ? '0 : s + 1'b1;
   endfunction

   function automatic logic [W-1:0] prev_row(input logic [W-1:0] s);
      return (s == '0) ? LAST : s - 1'b1;
   endfunction

   always_comb begin
      up_p  = btn_up    & ~up_q;
      dn_p  = btn_down  & ~dn_q;
      ent_p = btn_enter & ~ent_q;
      esc_p = btn_esc   & ~esc_q;
      row   = {1'b0, char_xy[7:4]};
      hl_en = 1'b0;
      case (state)
         S_MENU:    hl_en = 1'b1;
         S_CONFIRM: hl_en = blink_en;
         default:   hl_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_MENU;
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         ent_q       <= 1'b0;
         esc_q       <= 1'b0;
         up_arm      <= 1'b0;
         dn_arm      <= 1'b0;
         up_tmr      <= '0;
         dn_tmr      <= '0;
         blink_tmr   <= '0;
         blink_en    <= 1'b0;
         sel_item    <= '0;
         highlight   <= 1'b0;
         mode_valid  <= 1'b0;
         mode        <= '0;
         menu_active <= 1'b1;
      end else begin
         up_q  <= btn_up;
         dn_q  <= btn_down;
         ent_q <= btn_enter;
         esc_q <= btn_esc;

         highlight <= hl_en & (row == 5'(sel_item)) & (row < N_LIM);

         case (state)
            S_MENU: begin
               if (ent_p) begin
                  mode       <= sel_item;
                  mode_valid <= 1'b1;
                  state      <= S_CONFIRM;
                  blink_en   <= 1'b1;
                  blink_tmr  <= BLINK_DIV - 32'd1;
                  up_arm     <= 1'b0;
                  dn_arm     <= 1'b0;
                  up_tmr     <= '0;
                  dn_tmr     <= '0;
               end else if (btn_up & btn_down) begin
                  up_arm <= 1'b0;
                  dn_arm <= 1'b0;
                  up_tmr <= '0;
                  dn_tmr <= '0;
               end else begin
                  // Only one of the two buttons can be high here, so at most
                  // one branch below writes sel_item.
                  if (up_p) begin
                     sel_item <= prev_row(sel_item);
                     up_arm   <= 1'b1;
                     up_tmr   <= REPEAT_DELAY - 32'd1;
                  end else if (btn_up & up_arm) begin
                     if (up_tmr == '0) begin
                        sel_item <= prev_row(sel_item);
                        up_tmr   <= REPEAT_RATE - 32'd1;
                     end else begin
                        up_tmr <= up_tmr - 32'd1;
                     end
                  end else if (!btn_up) begin
                     up_arm <= 1'b0;
                     up_tmr <= '0;
                  end

                  if (dn_p) begin
                     sel_item <= next_row(sel_item);
                     dn_arm   <= 1'b1;
                     dn_tmr   <= REPEAT_DELAY - 32'd1;
                  end else if (btn_down & dn_arm) begin
                     if (dn_tmr == '0) begin
                        sel_item <= next_row(sel_item);
                        dn_tmr   <= REPEAT_RATE - 32'd1;
                     end else begin
                        dn_tmr <= dn_tmr - 32'd1;
                     end
                  end else if (!btn_down) begin
                     dn_arm <= 1'b0;
                     dn_tmr <= '0;
                  end
               end
            end

            S_CONFIRM: begin
               // A completed transfer takes priority over a same-cycle esc.
               if (mode_ready) begin
                  mode_valid  <= 1'b0;
                  state       <= S_RUN;
                  menu_active <= 1'b0;
               end else if (esc_p) begin
                  mode_valid <= 1'b0;
                  state      <= S_MENU;
               end
               if (blink_tmr == '0) begin
                  blink_en  <= ~blink_en;
                  blink_tmr <= BLINK_DIV - 32'd1;
               end else begin
                  blink_tmr <= blink_tmr - 32'd1;
               end
            end

            S_RUN: begin
               // Arms stay cleared, so buttons still held on return do not
               // repeat until released and pressed again.
               if (game_done | esc_p) begin
                  state       <= S_MENU;
                  menu_active <= 1'b1;
               end
            end

            default: begin
               state       <= S_MENU;
               mode_valid  <= 1'b0;
               menu_active <= 1'b1;
            end
         endcase
      end
   end

endmodule
